// File: rtl/fft8_seq_pkg.sv
// fft8_seq_pkg: shared sizes, twiddle constants, state types and index helper for the FFT8 frame sequencer
package fft8_seq_pkg;
  localparam int N_PT = 8;
  localparam int DW = 16;
  localparam int OW = 66;
  localparam logic [63:0] TW_RE = {16'hD2BF, 16'h0000, 16'h2D41, 16'h4000};
  localparam logic [63:0] TW_IM = {16'hD2BF, 16'hC000, 16'hD2BF, 16'h0000};
  typedef enum logic {FILL, FULL} in_state_t;
  typedef enum logic [1:0] {EMPTY, WAIT, DRAIN} out_state_t;
  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction
endpackage

// File: rtl/fft8_frame_buf.sv
// fft8_frame_buf: 8-slot sample buffer plus registered FFT input image (FFT8_BITREV_EN selects bit-reversed slot order)
module fft8_frame_buf
  import fft8_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [DW-1:0]      wr_data,
  input  logic               launch,
  output logic [N_PT*DW-1:0] fft_in
);
  logic [N_PT*DW-1:0] smp_q, smp_d, img_q, img_d;
  logic [2:0] slot;
`ifdef FFT8_BITREV_EN
  assign slot = bitrev3(wr_idx);
`else
  assign slot = wr_idx;
`endif
  assign fft_in = img_q;
  // place each accepted sample in its slot; snapshot the complete frame at launch
  always_comb begin
    smp_d = smp_q;
    if (wr_en) smp_d[slot*DW +: DW] = wr_data;
    img_d = launch ? smp_q : img_q;
  end
  // sample buffer and FFT input image; reset discards any partial frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q <= '0;
      img_q <= '0;
    end else begin
      smp_q <= smp_d;
      img_q <= img_d;
    end
  end
endmodule

// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer: frames serial samples for an 8-point FFT and drains its results one bin per beat (FFT8_BITREV_EN: bit-reversed input slots)
module fft8_frame_sequencer
  import fft8_seq_pkg::*;
#(
  parameter int FFT_LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  output logic [N_PT*DW-1:0] fft_in,
  output logic [63:0]        tw_real,
  output logic [63:0]        tw_imag,
  input  logic [N_PT*OW-1:0] fft_out_real,
  input  logic [N_PT*OW-1:0] fft_out_imag,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OW-1:0]      m_real,
  output logic [OW-1:0]      m_imag,
  output logic [2:0]         m_bin,
  output logic               m_last,
  output logic [15:0]        frame_cnt
);
  localparam int CW = FFT_LATENCY > 0 ? $clog2(FFT_LATENCY + 1) : 1;
  in_state_t in_q, in_d;
  out_state_t out_q, out_d;
  logic [2:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [N_PT*OW-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
  logic accept, launch, hs;
  assign s_ready = in_q == FILL;
  assign accept = s_valid && s_ready;
  assign launch = in_q == FULL && out_q == EMPTY;
  assign m_valid = out_q == DRAIN;
  assign hs = m_valid && m_ready;
  assign m_real = res_re_q[rd_idx_q*OW +: OW];
  assign m_imag = res_im_q[rd_idx_q*OW +: OW];
  assign m_bin = rd_idx_q;
  assign m_last = rd_idx_q == 3'd7;
  assign frame_cnt = frame_cnt_q;
  assign tw_real = TW_RE;
  assign tw_imag = TW_IM;
  fft8_frame_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_idx  (wr_idx_q),
    .wr_data (s_data),
    .launch  (launch),
    .fft_in  (fft_in)
  );
  // fill/launch handshake between the two FSMs, latency wait, result capture and drain
  always_comb begin
    in_d = in_q;
    out_d = out_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d = cnt_q;
    frame_cnt_d = frame_cnt_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    if (accept) begin
      wr_idx_d = wr_idx_q + 3'd1;
      in_d = wr_idx_q == 3'd7 ? FULL : FILL;
    end
    if (launch) begin
      in_d = FILL;
      out_d = WAIT;
      cnt_d = '0;
    end
    if (out_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(FFT_LATENCY)) begin
        out_d = DRAIN;
        res_re_d = fft_out_real;
        res_im_d = fft_out_imag;
      end
    end
    if (hs) begin
      rd_idx_d = rd_idx_q + 3'd1;
      if (m_last) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        out_d = EMPTY;
      end
    end
  end
  // state, indices, counters and captured results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q <= FILL;
      out_q <= EMPTY;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q <= '0;
      frame_cnt_q <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
    end else begin
      in_q <= in_d;
      out_q <= out_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
    end
  end
endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// tb_fft8_frame_sequencer: scoreboard bench with a behavioural DFT standing in for the FFT datapath
`timescale 1ns/1ps
module tb_fft8_frame_sequencer;
  import fft8_seq_pkg::*;
  localparam int LAT = 2;
  typedef logic [15:0] frame_t [8];
  typedef struct {
    logic [OW-1:0] re;
    logic [OW-1:0] im;
    logic [2:0]    bin;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst, s_valid, s_ready, m_valid, m_ready, m_last;
  logic [15:0] s_data, frame_cnt;
  logic [8*16-1:0] fft_in;
  logic [63:0] tw_real, tw_imag;
  logic [8*OW-1:0] fft_out_real, fft_out_imag;
  logic [OW-1:0] m_real, m_imag;
  logic [2:0] m_bin;
  frame_t env_x;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  fft8_frame_sequencer #(.FFT_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .fft_in       (fft_in),
    .tw_real      (tw_real),
    .tw_imag      (tw_imag),
    .fft_out_real (fft_out_real),
    .fft_out_imag (fft_out_imag),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_real       (m_real),
    .m_imag       (m_imag),
    .m_bin        (m_bin),
    .m_last       (m_last),
    .frame_cnt    (frame_cnt)
  );

  function automatic int mapk(input int k);
    logic [2:0] b;
    b = 3'(k);
`ifdef FFT8_BITREV_EN
    return {29'd0, b[0], b[1], b[2]};
`else
    return {29'd0, b};
`endif
  endfunction

  // X[k] = sum x[n] * W^(kn), W^m for m>=4 is -W^(m-4); twiddles Q2.14
  function automatic logic [OW-1:0] dft(input frame_t x, input int k, input bit im);
    logic signed [OW-1:0] acc;
    logic signed [15:0] t;
    logic signed [31:0] p;
    int m;
    acc = '0;
    for (int n = 0; n < 8; n++) begin
      m = (k * n) % 8;
      t = im ? TW_IM[(m % 4) * 16 +: 16] : TW_RE[(m % 4) * 16 +: 16];
      p = $signed(x[n]) * t;
      acc = acc + (m >= 4 ? -p : p);
    end
    return acc;
  endfunction

  // slot map(s) holds sample s (the map is its own inverse)
  always_comb begin
    for (int s = 0; s < 8; s++) env_x[s] = fft_in[mapk(s)*16 +: 16];
  end

  always_comb begin
    fft_out_real = '0;
    fft_out_imag = '0;
    for (int k = 0; k < 8; k++) begin
      fft_out_real[k*OW +: OW] = dft(env_x, k, 1'b0);
      fft_out_imag[k*OW +: OW] = dft(env_x, k, 1'b1);
    end
  end

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic put(input logic [15:0] d);
    int t = 0;
    s_valid = 1'b1;
    s_data = d;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      stalls++;
      t++;
      if (t > 300) begin
        timeout("s_ready_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send(input frame_t f);
    for (int i = 0; i < 8; i++) put(f[i]);
  endtask

  task automatic push_frame(input frame_t f);
    for (int k = 0; k < 8; k++) q.push_back('{dft(f, k, 1'b0), dft(f, k, 1'b1), 3'(k), k == 7});
  endtask

  task automatic check_latency();
    int t = 0;
    while (!m_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("first_valid_cycle", OW'(t), OW'(3 + LAT));
  endtask

  task automatic check_slots(input frame_t f);
    for (int s = 0; s < 8; s++) chk("fft_in_slot", OW'(fft_in[s*16 +: 16]), OW'(f[mapk(s)]));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q.size() != 0 || m_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  // monitor: pop and compare every handshaken bin; check hold behaviour on every stalled beat
  initial begin
    exp_t e;
    logic stall = 1'b0;
    logic [OW-1:0] h_re, h_im;
    logic [2:0] h_bin;
    forever begin
      @(negedge clk);
      if (rst && stall) begin
        chk("hold_valid", OW'(m_valid), OW'(1));
        chk("hold_real", m_real, h_re);
        chk("hold_imag", m_imag, h_im);
        chk("hold_bin", OW'(m_bin), OW'(h_bin));
      end
      stall = rst && m_valid && !m_ready;
      h_re = m_real;
      h_im = m_imag;
      h_bin = m_bin;
      if (rst && m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_bin: got bin %0d expected none", m_bin);
        end else begin
          e = q.pop_front();
          chk("bin_real", m_real, e.re);
          chk("bin_imag", m_imag, e.im);
          chk("bin_index", OW'(m_bin), OW'(e.bin));
          chk("bin_last", OW'(m_last), OW'(e.last));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    frame_t f1, f2, f3, f4a, f4b, f5;
    int z;
    f1 = '{16'd4095, 16'd4092, 16'd4094, 16'd4091, 16'd4091, 16'd4093, 16'd4093, 16'd4095};
    f2 = '{16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100};
    f3 = '{16'd1, 16'hFFFE, 16'd3, 16'hFFFC, 16'd5, 16'hFFFA, 16'd7, 16'hFFF8};
    f4a = '{16'h7FFF, 16'h8000, 16'd0, 16'd1234, 16'hABCD, 16'd42, 16'h0F0F, 16'd9};
    f4b = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    f5 = '{16'hDEAD, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", OW'(s_ready), OW'(1));
    chk("rst_m_valid", OW'(m_valid), OW'(0));
    chk("rst_frame_cnt", OW'(frame_cnt), OW'(0));
    chk("rst_fft_in", OW'(fft_in), OW'(0));
    chk("rst_m_real", m_real, OW'(0));
    chk("rst_m_bin", OW'(m_bin), OW'(0));
    chk("rst_m_last", OW'(m_last), OW'(0));
    chk("tw_real", OW'(tw_real), OW'(64'hD2BF_0000_2D41_4000));
    chk("tw_imag", OW'(tw_imag), OW'(64'hD2BF_C000_D2BF_0000));
    @(posedge clk);
    #1;
    rst = 1'b1;
    // T1: basic frame, latency and slot order
    push_frame(f1);
    send(f1);
    check_latency();
    check_slots(f1);
    wait_drain();
    chk("t1_frame_cnt", OW'(frame_cnt), OW'(1));
    // T2: DC frame, hand-computed bins
    q.push_back('{OW'(13107200), '0, 3'd0, 1'b0});
    for (int k = 1; k < 8; k++) q.push_back('{'0, '0, 3'(k), k == 7});
    send(f2);
    wait_drain();
    chk("t2_frame_cnt", OW'(frame_cnt), OW'(2));
    // T3: backpressure on bin 3
    m_ready = 1'b0;
    push_frame(f3);
    send(f3);
    z = 0;
    while (!m_valid && z < 100) begin
      @(negedge clk);
      z++;
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    z = 0;
    do begin
      @(negedge clk);
      z++;
    end while (m_bin != 3'd2 && z < 50);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_valid", OW'(m_valid), OW'(1));
      chk("t3_bin", OW'(m_bin), OW'(3));
      chk("t3_real", m_real, dft(f3, 3, 1'b0));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drain();
    chk("t3_frame_cnt", OW'(frame_cnt), OW'(3));
    // T4: two frames back to back, second fills during first drain
    push_frame(f4a);
    push_frame(f4b);
    stalls = 0;
    send(f4a);
    send(f4b);
    chk("t4_fill_stalls", OW'(stalls), OW'(1));
    z = 0;
    forever begin
      @(negedge clk);
      if (s_ready || z > 100) break;
      z++;
    end
    chk("t4_full_wait", OW'(z), OW'(2 + LAT));
    wait_drain();
    chk("t4_frame_cnt", OW'(frame_cnt), OW'(5));
    // T5: reset mid-frame, then a clean frame
    for (int i = 0; i < 5; i++) put(f5[i]);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_s_ready", OW'(s_ready), OW'(1));
    chk("t5_m_valid", OW'(m_valid), OW'(0));
    chk("t5_frame_cnt", OW'(frame_cnt), OW'(0));
    chk("t5_fft_in", OW'(fft_in), OW'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_frame(f1);
    send(f1);
    check_latency();
    check_slots(f1);
    wait_drain();
    chk("t5_frame_cnt_after", OW'(frame_cnt), OW'(1));
`ifdef FFT8_BITREV_EN
    begin
      frame_t f6, s6;
      f6 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
      s6 = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
      push_frame(f6);
      send(f6);
      check_latency();
      for (int s = 0; s < 8; s++) chk("t6_slot", OW'(fft_in[s*16 +: 16]), OW'(s6[s]));
      wait_drain();
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
